// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider. Divisor updates land on period
// boundaries, and a glitch-free selector switches one channel onto dclk.
module clk_div_prog #(
    parameter int CH  = 4,
    parameter int W   = 8,
    parameter int CHW = $clog2(CH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic [CHW-1:0] sel,
    output logic [CH-1:0]  clk_out,
    output logic [CH-1:0]  tick,
    output logic           dclk,
    output logic [CHW-1:0] dclk_cur,
    output logic           sw_busy
);
    typedef enum logic [1:0] {RUN, WAIT_LOW, WAIT_START} sel_state_e;

    localparam logic [CHW:0] CH_LIM = CH[CHW:0];

    // Reset divisor 2^(idx+1), saturated to all-ones when it does not fit in W bits.
    function automatic logic [W-1:0] reset_div(input int idx);
        if (idx + 1 >= W) return '1;
        return {{(W-1){1'b0}}, 1'b1} << (idx + 1);
    endfunction

    logic [CH-1:0]  w_wrap;
    logic [CH-1:0]  w_pending;
    logic [CH-1:0]  w_cfg_hit;
    logic           w_cfg_ok;
    logic           w_sel_ok;
    sel_state_e     r_state;
    sel_state_e     w_state_nxt;
    logic [CHW-1:0] r_cur;
    logic [CHW-1:0] r_tgt;
    logic [CHW-1:0] w_cur_nxt;
    logic [CHW-1:0] w_tgt_nxt;

    assign w_cfg_ok  = ({1'b0, cfg_ch} < CH_LIM);
    assign w_sel_ok  = ({1'b0, sel} < CH_LIM);
    assign cfg_ready = w_cfg_ok ? !w_pending[cfg_ch] : 1'b1;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_cfg_hit = '0;
        if (cfg_valid && cfg_ready && w_cfg_ok) w_cfg_hit[cfg_ch] = 1'b1;
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        localparam logic [W-1:0] RST_DIV = reset_div(g);

        logic [W-1:0] r_div;
        logic [W-1:0] r_cnt;
        logic [W-1:0] r_shadow;
        logic         r_pending;
        logic         r_clk;
        logic         r_tick;
        logic [W-1:0] w_div_nxt;
        logic [W-1:0] w_cnt_nxt;
        logic [W-1:0] w_half_nxt;
        logic         w_idle;
        logic         w_apply;

        // A stopped channel has no wrap, so its pending update lands on the very next edge.
        assign w_idle     = (r_div == '0);
        assign w_wrap[g]  = !w_idle && (r_cnt == r_div - 1'b1);
        assign w_apply    = r_pending && (w_wrap[g] || w_idle);
        assign w_div_nxt  = w_apply ? r_shadow : r_div;
        assign w_cnt_nxt  = (w_div_nxt == '0 || w_wrap[g] || w_idle) ? '0 : r_cnt + 1'b1;
        assign w_half_nxt = (w_div_nxt >> 1) + {{(W-1){1'b0}}, w_div_nxt[0]};

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            if (rst) begin
                r_div     <= RST_DIV;
                r_cnt     <= RST_DIV - 1'b1;
                r_shadow  <= '0;
                r_pending <= 1'b0;
                r_clk     <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_div  <= w_div_nxt;
                r_cnt  <= w_cnt_nxt;
                r_clk  <= (w_div_nxt != '0) && (w_cnt_nxt < w_half_nxt);
                r_tick <= (w_div_nxt != '0) && (w_cnt_nxt == '0);
                if (w_apply) begin
                    r_pending <= 1'b0;
                end else if (w_cfg_hit[g]) begin
                    r_pending <= 1'b1;
                    r_shadow  <= cfg_div;
                end
            end
        end

        assign w_pending[g] = r_pending;
        assign clk_out[g]   = r_clk;
        assign tick[g]      = r_tick;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_tgt_nxt   = r_tgt;
        case (r_state)
            RUN: begin
                if (w_sel_ok && sel != r_cur) begin
                    w_tgt_nxt   = sel;
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (w_sel_ok) w_tgt_nxt = sel;
                if (!clk_out[r_cur]) w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                // Handover happens on the target's wrap, so its first dclk period is whole.
                if (w_sel_ok) w_tgt_nxt = sel;
                if (w_wrap[r_tgt]) begin
                    w_cur_nxt   = r_tgt;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cur   <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    assign dclk     = (r_state != WAIT_START) && clk_out[r_cur];
    assign dclk_cur = r_cur;
    assign sw_busy  = (r_state != RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic, all outputs
// compared every cycle against a period/phase reference model.
module tb_clk_div_prog;
    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [W-1:0]   cfg_div = '0;
    logic [CHW-1:0] sel = '0;
    logic [CH-1:0]  clk_out;
    logic [CH-1:0]  tick;
    logic           dclk;
    logic [CHW-1:0] dclk_cur;
    logic           sw_busy;

    clk_div_prog #(.CH(CH), .W(W), .CHW(CHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .sel       (sel),
        .clk_out   (clk_out),
        .tick      (tick),
        .dclk      (dclk),
        .dclk_cur  (dclk_cur),
        .sw_busy   (sw_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: period length, position within the period, queued divisor.
    int m_d   [CH];
    int m_pos [CH];
    int m_sh  [CH];
    bit m_pend[CH];
    bit m_clk [CH];
    bit m_tick[CH];
    int m_mode;
    int m_cur;
    int m_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int default_period(input int i);
        int p;
        p = 1 << (i + 1);
        return (p > (1 << W) - 1) ? (1 << W) - 1 : p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_d[i]    = default_period(i);
            m_pos[i]  = m_d[i] - 1;
            m_sh[i]   = 0;
            m_pend[i] = 1'b0;
            m_clk[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
        m_mode = 0;
        m_cur  = 0;
        m_tgt  = 0;
    endtask

    task automatic model_step();
        bit accept;
        int ach;
        bit tgt_ends;
        bit cur_high;
        bit boundary;
        if (rst) begin
            model_reset();
            return;
        end
        ach      = int'(cfg_ch);
        accept   = cfg_valid && !m_pend[ach];
        tgt_ends = (m_d[m_tgt] != 0) && (m_pos[m_tgt] == m_d[m_tgt] - 1);
        cur_high = m_clk[m_cur];
        case (m_mode)
            0: if (int'(sel) != m_cur) begin
                m_tgt  = int'(sel);
                m_mode = 1;
            end
            1: begin
                m_tgt = int'(sel);
                if (!cur_high) m_mode = 2;
            end
            default: begin
                if (tgt_ends) begin
                    m_cur  = m_tgt;
                    m_mode = 0;
                end
                m_tgt = int'(sel);
            end
        endcase
        for (int i = 0; i < CH; i++) begin
            boundary = (m_d[i] == 0) || (m_pos[i] == m_d[i] - 1);
            if (boundary && m_pend[i]) begin
                m_d[i]    = m_sh[i];
                m_pend[i] = 1'b0;
            end
            if (m_d[i] == 0 || boundary) m_pos[i] = 0;
            else m_pos[i] = m_pos[i] + 1;
            m_clk[i]  = (m_d[i] != 0) && (2 * m_pos[i] < m_d[i]);
            m_tick[i] = (m_d[i] != 0) && (m_pos[i] == 0);
        end
        if (accept) begin
            m_sh[ach]   = int'(cfg_div);
            m_pend[ach] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] e_clk;
        logic [CH-1:0] e_tick;
        for (int i = 0; i < CH; i++) begin
            e_clk[i]  = m_clk[i];
            e_tick[i] = m_tick[i];
        end
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("tick", 32'(tick), 32'(e_tick));
        check("dclk", 32'(dclk), 32'(m_mode != 2 && m_clk[m_cur]));
        check("dclk_cur", 32'(dclk_cur), m_cur);
        check("sw_busy", 32'(sw_busy), 32'(m_mode != 0));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[int'(cfg_ch)]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg_write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = W'(div);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        run(2);
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_dclk", 32'(dclk), 32'h0);
        check("reset_busy", 32'(sw_busy), 32'h0);
        check("reset_ready", 32'(cfg_ready), 32'h1);

        rst = 1'b0;
        cycle();
        check("first_tick_aligned", 32'(tick), 32'hF);
        check("first_clk_high", 32'(clk_out), 32'hF);
        run(37);

        cfg_write(2, 5);
        check("ch2_ready_pending", 32'(cfg_ready), 32'h0);
        run(30);

        for (int k = 0; k < 8 && !m_clk[0]; k++) cycle();
        check("ch0_high_pre_switch", 32'(clk_out[0]), 32'h1);
        sel = 2'd3;
        cycle();
        check("switch_busy", 32'(sw_busy), 32'h1);
        run(40);
        check("switch_done_cur3", 32'(dclk_cur), 32'h3);

        cfg_write(1, 0);
        run(8);
        check("ch1_stopped_low", 32'(clk_out[1]), 32'h0);
        sel = 2'd1;
        run(30);
        check("stuck_wait_busy", 32'(sw_busy), 32'h1);
        check("stuck_wait_dclk", 32'(dclk), 32'h0);
        cfg_write(1, 3);
        run(20);
        check("restart_cur1", 32'(dclk_cur), 32'h1);

        cfg_write(0, 1);
        run(6);
        check("div1_clk_const", 32'(clk_out[0]), 32'h1);
        check("div1_tick_const", 32'(tick[0]), 32'h1);
        cycle();
        check("div1_clk_const2", 32'(clk_out[0]), 32'h1);

        sel = 2'd0;
        cfg_write(3, 7);
        check("midswitch_busy", 32'(sw_busy), 32'h1);
        check("midswitch_pending", 32'(cfg_ready), 32'h0);
        rst = 1'b1;
        cycle();
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_busy", 32'(sw_busy), 32'h0);
        check("rst_cur", 32'(dclk_cur), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        cycle();
        check("rst_restart_tick", 32'(tick), 32'hF);
        run(20);

        for (int k = 0; k < 3000; k++) begin
            cfg_valid = ($urandom_range(7) == 0);
            cfg_ch    = CHW'($urandom_range(CH - 1));
            cfg_div   = ($urandom_range(9) == 0) ? W'($urandom_range(255)) : W'($urandom_range(12));
            if ($urandom_range(24) == 0) sel = CHW'($urandom_range(CH - 1));
            rst = ($urandom_range(599) == 0);
            cycle();
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable, multi-channel clock divider. Generates CH divided clock signals (registered, single clock domain) plus one-cycle period ticks.
- A glitch-free selector drives one channel onto dclk.
- Divisors are reprogrammed through a valid/ready config port, and a new divisor takes effect only at a period boundary.
- Serves as the general divider for display-scan, debounce-sampling and blink timing logic.

Parameters:
- CH, 4, number of divider channels (2..16).
- W, 8, divisor width. Legal divisor range is 0..2^W-1.
- CHW, $clog2(CH), width of channel index fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  divisor update request.
- cfg_ready  out  1  update can be accepted for cfg_ch.
- cfg_ch  in  CHW  channel targeted by the update.
- cfg_div  in  W  new divisor. 0 stops the channel.
- sel  in  CHW  requested dclk source channel.
- clk_out  out  CH  divided clock per channel (registered).
- tick  out  CH  one-cycle pulse at start of each period (registered).
- dclk  out  1  selected clock, glitch-free across switches.
- dclk_cur  out  CHW  channel currently driving dclk.
- sw_busy  out  1  a source switch is in progress.

Behaviour:
- Per channel i:
  - Holds active divisor D_i, counter cnt_i (W bits) and H_i = ceil(D_i/2).
  - Invariants while running: clk_out[i] = (cnt_i < H_i); tick[i] = (cnt_i == 0).
  - Both outputs are registered, computed from the next counter value.
  - Counter runs 0..D_i-1, then wraps to 0. wrap_i = (cnt_i == D_i-1) and D_i != 0.
- Duty cycle:
  - Even D: exactly 50%.
  - Odd D: high ceil(D/2) cycles, low floor(D/2) cycles. No negedge logic.
  - D = 1: clk_out and tick constant 1.
- Reset:
  - D_i = 2^(i+1), saturated to 2^W-1 if it does not fit.
  - cnt_i = D_i-1, clk_out = 0, tick = 0.
  - Shadow registers cleared and no updates pending.
  - Mux state RUN, dclk_cur = 0, dclk = 0, sw_busy = 0, cfg_ready = 1.
  - First edge after reset release: cnt_i = 0, clk_out[i] = 1, tick[i] = 1, so every channel starts a full period together.
  - Reset asserted mid-operation: all of the above restored on the next edge. Any pending update and any in-flight switch are discarded.
- Config port:
  - Handshake fires when cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_ch], combinational on cfg_ch.
  - Accepted value goes to shadow_i and sets pending_i.
  - A running channel applies the shadow on its wrap edge (the new period starts with cnt = 0 under the new D). A stopped channel applies it on the next edge.
  - Updates are never applied mid-period, so there are no truncated or stretched periods.
- Stop/restart:
  - Channel stops when new D = 0 takes effect. Held state is cnt = 0, clk_out = 0, tick = 0.
  - Restart (nonzero D applied to a stopped channel): next edge gives cnt = 0, clk_out = 1, tick = 1.
- Selector FSM, states RUN, WAIT_LOW, WAIT_START. tgt is an internal register.
  - RUN: dclk = clk_out[dclk_cur]. When sel != dclk_cur and sel < CH: tgt <= sel, go to WAIT_LOW.
  - WAIT_LOW: dclk = clk_out[dclk_cur]. When clk_out[dclk_cur] == 0 (includes a stopped channel), go to WAIT_START.
  - WAIT_START: dclk forced 0. On wrap_tgt: dclk_cur <= tgt, go to RUN. The new source's first dclk period is complete.
  - Stopped target: FSM stays in WAIT_START, dclk = 0.
  - sel changing during WAIT_LOW or WAIT_START retargets tgt. If sel returns to dclk_cur during WAIT_START, the FSM still waits for that channel's wrap.
  - sel >= CH is ignored (treated as unchanged).
- dclk gating: dclk is formed only from registered state and clk_out, giving no high pulse shorter than the source's high phase and no low pulse shorter than one clk.
- sw_busy = (state != RUN).
- Simultaneous events: a config update and a switch to the same channel may coincide. The wrap that applies the new D is also the wrap that completes the switch, so dclk starts at the new D.

Test Plan:
- Reset released with defaults (CH = 4, W = 8) -> periods 2/4/8/16. Ticks aligned on the first cycle. dclk equals clk_out[0].
- cfg_ch = 2, cfg_div = 5 accepted mid-period -> channel 2 finishes its 8-cycle period, then shows 3 high / 2 low repeating. cfg_ready for ch2 is low until the wrap edge.
- sel 0 -> 3 while ch0 is high -> dclk completes ch0's high phase, holds low until ch3's wrap, then shows a full 8-high/8-low period. sw_busy is high throughout the switch.
- cfg_div = 0 on ch1, then sel = 1 -> ch1 holds low after its boundary. FSM sticks in WAIT_START with dclk = 0. Loading cfg_div = 3 restarts ch1 and dclk follows a 2-high/1-low pattern after the next wrap.
- cfg_div = 1 on ch0 -> clk_out[0] and tick[0] stay constant 1 from the boundary onward.
- rst pulsed mid-switch with a pending update -> next edge shows all defaults restored, sw_busy = 0 and pending cleared.
